pix_tx: RTL and testbench



---
 rtl/pix_pkg.sv | 38 +++
 rtl/pix_tx_fifo.sv | 49 ++++
 rtl/pix_tx.sv | 131 +++++++++++++
 tb/tb_pix_tx.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pix_pkg.sv
// Shared PIX bus definitions: device ids, frame field layout and frame builder.
// Used by both the transmitter and the receiver.
package pix_pkg;

  localparam logic [2:0] DEV_RIA  = 3'd0;
  localparam logic [2:0] DEV_OPL  = 3'd2;
  localparam logic [2:0] DEV_IDLE = 3'd7;

  localparam int unsigned FRAME_W     = 32;
  localparam int unsigned DEV_MSB     = 31;
  localparam int unsigned DEV_LSB     = 29;
  localparam int unsigned FRAMING_BIT = 28;
  localparam int unsigned CH_MSB      = 27;
  localparam int unsigned CH_LSB      = 24;
  localparam int unsigned ADDR_MSB    = 23;
  localparam int unsigned ADDR_LSB    = 16;
  localparam int unsigned VAL_MSB     = 15;
  localparam int unsigned VAL_LSB     = 0;

  localparam logic [3:0] PIX_IDLE_NIBBLE = 4'hF;

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StGap} pix_tx_state_e;

  function automatic logic [FRAME_W-1:0] pix_frame(input logic [2:0]  device,
                                                   input logic [3:0]  channel,
                                                   input logic [7:0]  addr,
                                                   input logic [15:0] value);
    logic [FRAME_W-1:0] w;
    w                     = '0;
    w[DEV_MSB:DEV_LSB]    = device;
    w[FRAMING_BIT]        = 1'b1;
    w[CH_MSB:CH_LSB]      = channel;
    w[ADDR_MSB:ADDR_LSB]  = addr;
    w[VAL_MSB:VAL_LSB]    = value;
    return w;
  endfunction

endpackage

// File: rtl/pix_tx_fifo.sv
// Request FIFO for the PIX transmitter. Storage is a flop array, so the head
// word is presented directly from registers without an extra read cycle.
module pix_tx_fifo #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned WIDTH      = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [WIDTH-1:0]              wr_data,
  input  logic                          pop,
  output logic [WIDTH-1:0]              rd_data,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          full,
  output logic                          empty
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok, pop_ok;

  assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok)      count_q <= count_q + 1'b1;
      else if (pop_ok && !push_ok) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/pix_tx.sv
// PIX bus transmitter: buffers frame requests and serialises each 32-bit frame
// MSB nibble first on a 4-bit DDR link, generating phi2 at clk/4.
module pix_tx
  import pix_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned MIN_GAP    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_device,
  input  logic [3:0]  in_channel,
  input  logic [7:0]  in_addr,
  input  logic [15:0] in_value,
  output logic        phi2_out,
  output logic [3:0]  pix_out,
  output logic        busy,
  output logic [15:0] frames_sent
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned GW = $clog2(MIN_GAP + 1);

  pix_tx_state_e state_q, state_d;
  logic [1:0]    ph_q;
  logic          phi2_q;
  logic [3:0]    pix_q, pix_d;
  logic [31:0]   sreg_q, sreg_d;
  logic [2:0]    nib_q, nib_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [15:0]   frames_q, frames_d;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [31:0]   fifo_head;
  logic [CW-1:0] fifo_count;
  logic          slot;

  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && in_ready;

  pix_tx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (32)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .wr_data (pix_frame(in_device, in_channel, in_addr, in_value)),
    .pop     (fifo_pop),
    .rd_data (fifo_head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Slot edges: leaving ph2 (nibble enters ph3) and leaving ph0 (enters ph1).
  assign slot = (ph_q == 2'd2) || (ph_q == 2'd0);

  always_comb begin
    state_d  = state_q;
    pix_d    = pix_q;
    sreg_d   = sreg_q;
    nib_d    = nib_q;
    gap_d    = gap_q;
    frames_d = frames_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty && gap_q == '0 && ph_q == 2'd2) begin
          fifo_pop = 1'b1;
          pix_d    = fifo_head[31:28];
          sreg_d   = {fifo_head[27:0], PIX_IDLE_NIBBLE};
          nib_d    = 3'd1;
          state_d  = StLoad;
        end
      end
      StLoad: state_d = StShift;
      StShift: begin
        if (slot) begin
          pix_d  = sreg_q[31:28];
          sreg_d = {sreg_q[27:0], PIX_IDLE_NIBBLE};
          nib_d  = nib_q + 3'd1;
          if (nib_q == 3'd7) begin
            frames_d = frames_q + 16'd1;
            gap_d    = GW'(MIN_GAP);
            state_d  = StGap;
          end
        end
      end
      StGap: begin
        if (slot) begin
          pix_d = PIX_IDLE_NIBBLE;
          gap_d = gap_q - 1'b1;
          if (gap_q == GW'(1)) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      ph_q     <= 2'd0;
      phi2_q   <= 1'b0;
      pix_q    <= PIX_IDLE_NIBBLE;
      sreg_q   <= '0;
      nib_q    <= 3'd0;
      gap_q    <= '0;
      frames_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      ph_q     <= ph_q + 2'd1;
      // phi2 is high while the phase being entered is 2 or 3.
      phi2_q   <= (ph_q == 2'd1) || (ph_q == 2'd2);
      pix_q    <= pix_d;
      sreg_q   <= sreg_d;
      nib_q    <= nib_d;
      gap_q    <= gap_d;
      frames_q <= frames_d;
    end
  end

  assign phi2_out    = phi2_q;
  assign pix_out     = pix_q;
  assign frames_sent = frames_q;
  assign busy        = (fifo_count != '0) || (state_q != StIdle) || (gap_q != '0);

endmodule

// File: tb/tb_pix_tx.sv
// Scoreboard bench for pix_tx: stimulus pushes expected frame words, a phi2-edge
// receiver recovers frames from pix_out and compares them in order.
module tb_pix_tx;
  import pix_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_device = '0;
  logic [3:0]  in_channel = '0;
  logic [7:0]  in_addr = '0;
  logic [15:0] in_value = '0;
  logic        phi2_out;
  logic [3:0]  pix_out;
  logic        busy;
  logic [15:0] frames_sent;

  int checks = 0;
  int errors = 0;
  int slot_n = 0;
  logic [31:0] exp_q[$];
  logic [31:0] rx_log[$];
  int          start_q[$];

  initial forever #5 clk = ~clk;

  pix_tx #(
    .FIFO_DEPTH (16),
    .MIN_GAP    (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_device   (in_device),
    .in_channel  (in_channel),
    .in_addr     (in_addr),
    .in_value    (in_value),
    .phi2_out    (phi2_out),
    .pix_out     (pix_out),
    .busy        (busy),
    .frames_sent (frames_sent)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] d, input logic [3:0] c, input logic [7:0] a,
                      input logic [15:0] v, input logic [31:0] w);
    int n;
    n = 0;
    if (d == DEV_IDLE) $display("note: reserved device id driven");
    in_device = d; in_channel = c; in_addr = a; in_value = v; in_valid = 1'b1;
    while (!in_ready && n < 100) begin step(1); n++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL push_ready: in_ready 0 after %0d clk, required 1", n);
    end else begin
      exp_q.push_back(w);
    end
    step(1);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    int n;
    n = 0;
    while (busy && n < max_cyc) begin step(1); n++; end
    check(name, 32'(busy), 32'd0);
  endtask

  // Receiver: a frame starts with a non-idle nibble on a falling phi2 edge.
  initial begin : rx_monitor
    logic [31:0] word;
    int          nib;
    bit          in_frame;
    word = '0; nib = 0; in_frame = 1'b0;
    forever begin
      @(phi2_out or posedge rst);
      if (rst || $isunknown(phi2_out)) begin
        in_frame = 1'b0;
      end else begin
        slot_n++;
        if (!in_frame) begin
          if (!phi2_out && pix_out !== PIX_IDLE_NIBBLE) begin
            in_frame = 1'b1; nib = 1; word = {28'h0, pix_out};
            start_q.push_back(slot_n);
          end
        end else begin
          word = {word[27:0], pix_out};
          nib++;
          if (nib == 8) begin
            in_frame = 1'b0;
            rx_log.push_back(word);
            if (exp_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL rx_frame: got %h required no frame", word);
            end else begin
              check("rx_frame", word, exp_q.pop_front());
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin : main
    int          n;
    logic        en;
    logic [7:0]  latch;
    logic [15:0] opl_q[$];
    logic [31:0] w;

    step(3);
    check("rst_phi2", 32'(phi2_out), 32'd0);
    check("rst_pix", 32'(pix_out), 32'hF);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frames", 32'(frames_sent), 32'd0);
    rst = 1'b0;

    // Single frame; push lands on the edge leaving ph0, nibble 0 shows 2 clk later.
    push(DEV_RIA, 4'h0, 8'h41, 16'hFF01, 32'h1041FF01);
    check("t1_busy_after_push", 32'(busy), 32'd1);
    check("t1_pix_before", 32'(pix_out), 32'hF);
    step(2);
    check("t1_nibble0", 32'(pix_out), 32'h1);
    check("t1_phi2_at_ph3", 32'(phi2_out), 32'd1);
    step(17);
    check("t1_busy_in_gap", 32'(busy), 32'd1);
    step(1);
    check("t1_busy_fall", 32'(busy), 32'd0);
    check("t1_frames", 32'(frames_sent), 32'd1);

    // Three back-to-back frames: starts exactly 10 slots apart.
    start_q.delete();
    push(DEV_OPL, 4'h3, 8'h12, 16'h3456, 32'h53123456);
    push(3'd0,    4'hA, 8'h5A, 16'hA55A, 32'h1A5AA55A);
    push(3'd6,    4'hF, 8'hFF, 16'h0000, 32'hDFFF0000);
    wait_idle("t2_idle", 200);
    check("t2_starts", 32'(start_q.size()), 32'd3);
    if (start_q.size() == 3) begin
      check("t2_spacing_a", 32'(start_q[1] - start_q[0]), 32'd10);
      check("t2_spacing_b", 32'(start_q[2] - start_q[1]), 32'd10);
    end
    check("t2_frames", 32'(frames_sent), 32'd4);

    // Fill: 17 pushes with one frame popped leaves the FIFO full.
    for (int i = 0; i < 17; i++)
      push(3'd1, 4'(i), 8'(i * 3), 16'(16'hC000 + i),
           {3'd1, 1'b1, 4'(i), 8'(i * 3), 16'(16'hC000 + i)});
    check("t3_full_ready", 32'(in_ready), 32'd0);
    n = 0;
    while (!in_ready && n < 40) begin step(1); n++; end
    check("t3_ready_back", 32'(in_ready), 32'd1);
    check("t3_ready_with_pop", 32'(pix_out), 32'h3);
    push(3'd1, 4'h0, 8'hEE, 16'h1234, 32'h30EE1234);
    wait_idle("t3_idle", 600);
    check("t3_exp_drained", 32'(exp_q.size()), 32'd0);
    check("t3_frames", 32'(frames_sent), 32'd22);

    // Reset during nibble 4 of a frame.
    push(DEV_RIA, 4'h0, 8'hC3, 16'h9E27, 32'h10C39E27);
    push(DEV_RIA, 4'h1, 8'h22, 16'h3333, 32'h11223333);
    n = 0;
    while (pix_out === 4'hF && n < 20) begin step(1); n++; end
    check("t4_nibble0", 32'(pix_out), 32'h1);
    step(8);
    check("t4_nibble4", 32'(pix_out), 32'h9);
    rst = 1'b1;
    step(1);
    exp_q.delete();
    check("t4_pix", 32'(pix_out), 32'hF);
    check("t4_phi2", 32'(phi2_out), 32'd0);
    check("t4_frames", 32'(frames_sent), 32'd0);
    check("t4_in_ready", 32'(in_ready), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    step(2);
    rst = 1'b0;
    step(12);
    check("t4_fifo_dropped", 32'(busy), 32'd0);
    check("t4_pix_idle", 32'(pix_out), 32'hF);

    // Counter wrap from 16'hFFFF.
    force dut.frames_q = 16'hFFFF;
    step(1);
    release dut.frames_q;
    check("t5_preload", 32'(frames_sent), 32'h0000FFFF);
    push(DEV_RIA, 4'h0, 8'h00, 16'h0000, 32'h10000000);
    wait_idle("t5_idle", 100);
    check("t5_wrap", 32'(frames_sent), 32'd0);

    // OPL2 loopback: enable card, latch register 0x20, write 0x01.
    push(DEV_OPL, 4'h0, 8'h00, 16'h0001, 32'h50000001);
    push(DEV_RIA, 4'h0, 8'h20, 16'hFF00, 32'h1020FF00);
    push(DEV_RIA, 4'h0, 8'h01, 16'hFF01, 32'h1001FF01);
    wait_idle("t6_idle", 200);
    en = 1'b0; latch = '0;
    for (int i = 0; i < rx_log.size(); i++) begin
      if (i + 3 >= rx_log.size()) begin
        w = rx_log[i];
        if (w[31:29] == DEV_OPL && w[27:16] == 12'h000) en = w[0];
        else if (w[31:29] == DEV_RIA && w[15:0] == 16'hFF00) latch = w[23:16];
        else if (w[31:29] == DEV_RIA && w[15:0] == 16'hFF01 && en) opl_q.push_back({latch, w[23:16]});
      end
    end
    check("t6_opl_count", 32'(opl_q.size()), 32'd1);
    if (opl_q.size() > 0) check("t6_opl_word", 32'(opl_q[0]), 32'h2001);
    check("t6_exp_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
